// File: rtl/regfile_pkg.sv
// Shared types and default sizes for the multi-port register file.
package regfile_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } clr_state_e;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_NRD    = 2;

endpackage

// File: rtl/regfile_clr_fsm.sv
// Bulk-clear sequencer: walks entries 1..DEPTH-1 one per cycle, then pulses done.
module regfile_clr_fsm
  import regfile_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              clr_req_i,
  output logic              idle_o,
  output logic              clr_busy_o,
  output logic              clr_done_o,
  output logic              clr_we_o,
  output logic [ADDR_W-1:0] clr_addr_o
);

  localparam logic [ADDR_W-1:0] LAST = {ADDR_W{1'b1}};

  clr_state_e        state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic              busy_q;
  logic              done_q;

  // Entry 0 is hard-wired to zero, so the walk starts at 1 and parks at LAST.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (clr_req_i) begin
            state_q <= CLEAR;
            cnt_q   <= ADDR_W'(1);
            busy_q  <= 1'b1;
          end
        end
        CLEAR: begin
          if (cnt_q == LAST) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + ADDR_W'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign idle_o     = (state_q == IDLE);
  assign clr_busy_o = busy_q;
  assign clr_done_o = done_q;
  assign clr_we_o   = (state_q == CLEAR);
  assign clr_addr_o = cnt_q;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-read-port register file with write bypass,
// per-entry pending bits and a sequenced bulk clear.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NRD    = DEF_NRD,
  parameter int BYPASS = 1
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  input  logic [NRD*ADDR_W-1:0] rd_addr_i,
  output logic [NRD*DATA_W-1:0] rd_data_o,
  output logic [NRD-1:0]        rd_pend_o,
  input  logic                  wr_en_i,
  input  logic [ADDR_W-1:0]     wr_addr_i,
  input  logic [DATA_W-1:0]     wr_data_i,
  input  logic                  rsv_en_i,
  input  logic [ADDR_W-1:0]     rsv_addr_i,
  input  logic                  clr_req_i,
  output logic                  clr_busy_o,
  output logic                  clr_done_o
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0]  pend_q;
  logic [DEPTH-1:0]  pend_d;

  logic              idle;
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              wr_ok;
  logic              rsv_ok;

  regfile_clr_fsm #(
    .ADDR_W(ADDR_W)
  ) u_clr_fsm (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .clr_req_i  (clr_req_i),
    .idle_o     (idle),
    .clr_busy_o (clr_busy_o),
    .clr_done_o (clr_done_o),
    .clr_we_o   (clr_we),
    .clr_addr_o (clr_addr)
  );

  assign wr_ok  = wr_en_i  && idle && (wr_addr_i  != '0);
  assign rsv_ok = rsv_en_i && idle && (rsv_addr_i != '0);

  // Reserve is applied last so it wins over a same-address write.
  always_comb begin
    mem_d  = mem_q;
    pend_d = pend_q;
    if (clr_we) begin
      mem_d[clr_addr]  = '0;
      pend_d[clr_addr] = 1'b0;
    end
    if (wr_ok) begin
      mem_d[wr_addr_i]  = wr_data_i;
      pend_d[wr_addr_i] = 1'b0;
    end
    if (rsv_ok) begin
      pend_d[rsv_addr_i] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      pend_q <= '0;
    end else begin
      mem_q  <= mem_d;
      pend_q <= pend_d;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic              byp;

    assign addr = rd_addr_i[k*ADDR_W +: ADDR_W];
    assign byp  = (BYPASS != 0) && wr_en_i && idle && (wr_addr_i == addr);

    assign rd_data_o[k*DATA_W +: DATA_W] = (addr == '0) ? '0 :
                                           byp          ? wr_data_i :
                                                          mem_q[addr];
    assign rd_pend_o[k] = pend_q[addr];
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp (32x32, two read ports).
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        resetN;
  logic [9:0]  rdAddr;
  logic [63:0] rdData;
  logic [1:0]  rdPend;
  logic        wrEn;
  logic [4:0]  wrAddr;
  logic [31:0] wrData;
  logic        rsvEn;
  logic [4:0]  rsvAddr;
  logic        clrReq;
  logic        clrBusy;
  logic        clrDone;

  logic [63:0] nbRdData;
  logic [1:0]  nbRdPend;
  logic        nbClrBusy;
  logic        nbClrDone;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NRD(2), .BYPASS(1)) dut (
    .clk_i(clk), .reset_n_i(resetN), .rd_addr_i(rdAddr), .rd_data_o(rdData),
    .rd_pend_o(rdPend), .wr_en_i(wrEn), .wr_addr_i(wrAddr), .wr_data_i(wrData),
    .rsv_en_i(rsvEn), .rsv_addr_i(rsvAddr), .clr_req_i(clrReq),
    .clr_busy_o(clrBusy), .clr_done_o(clrDone)
  );

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NRD(2), .BYPASS(0)) dutNoByp (
    .clk_i(clk), .reset_n_i(resetN), .rd_addr_i(rdAddr), .rd_data_o(nbRdData),
    .rd_pend_o(nbRdPend), .wr_en_i(wrEn), .wr_addr_i(wrAddr), .wr_data_i(wrData),
    .rsv_en_i(rsvEn), .rsv_addr_i(rsvAddr), .clr_req_i(clrReq),
    .clr_busy_o(nbClrBusy), .clr_done_o(nbClrDone)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                               input logic re, input logic [4:0] ra, input logic cr);
    wrEn    = we;
    wrAddr  = wa;
    wrData  = wd;
    rsvEn   = re;
    rsvAddr = ra;
    clrReq  = cr;
  endtask

  task automatic setRead(input logic [4:0] a0, input logic [4:0] a1);
    rdAddr = {a1, a0};
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int busyCount;
    int doneCount;
    int busyAtDone;
    logic [31:0] orData;
    logic        orPend;
    logic        sawDone;

    resetN = 1'b0;
    rdAddr = '0;
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0);
    repeat (2) tick();
    checkOutput("rst_busy", {63'd0, clrBusy}, 64'd0);
    checkOutput("rst_done", {63'd0, clrDone}, 64'd0);
    resetN = 1'b1;
    tick();

    setRead(5'd0, 5'd3);
    checkOutput("rst_rd_0_3", rdData, 64'd0);
    checkOutput("rst_pend_0_3", {62'd0, rdPend}, 64'd0);
    setRead(5'd31, 5'd31);
    checkOutput("rst_rd_31", rdData, 64'd0);
    checkOutput("rst_pend_31", {62'd0, rdPend}, 64'd0);

    applyStimulus(1'b1, 5'd8, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0);
    tick();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0);
    setRead(5'd8, 5'd0);
    checkOutput("wr_rd_p0", {32'd0, rdData[31:0]}, 64'hDEADBEEF);
    checkOutput("wr_rd_p1", {32'd0, rdData[63:32]}, 64'd0);

    applyStimulus(1'b1, 5'd4, 32'h00001111, 1'b0, 5'd0, 1'b0);
    tick();
    applyStimulus(1'b1, 5'd4, 32'h12345678, 1'b0, 5'd0, 1'b0);
    setRead(5'd0, 5'd4);
    checkOutput("byp_p1", {32'd0, rdData[63:32]}, 64'h12345678);
    checkOutput("nobyp_p1_old", {32'd0, nbRdData[63:32]}, 64'h00001111);
    checkOutput("byp_p0_zero", {32'd0, rdData[31:0]}, 64'd0);
    tick();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0);
    setRead(5'd0, 5'd4);
    checkOutput("nobyp_p1_new", {32'd0, nbRdData[63:32]}, 64'h12345678);

    applyStimulus(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 1'b0);
    setRead(5'd0, 5'd0);
    checkOutput("e0_byp_zero", rdData, 64'd0);
    tick();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0);
    setRead(5'd0, 5'd0);
    checkOutput("e0_rd_zero", rdData, 64'd0);
    checkOutput("e0_pend_zero", {62'd0, rdPend}, 64'd0);

    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 1'b0);
    tick();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0);
    setRead(5'd5, 5'd0);
    checkOutput("rsv_pend5", {62'd0, rdPend}, 64'd1);
    applyStimulus(1'b1, 5'd5, 32'h000000A5, 1'b0, 5'd0, 1'b0);
    setRead(5'd5, 5'd0);
    checkOutput("pend_not_bypassed", {62'd0, rdPend}, 64'd1);
    tick();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0);
    setRead(5'd5, 5'd0);
    checkOutput("wr_clears_pend5", {62'd0, rdPend}, 64'd0);
    checkOutput("wr_data5", {32'd0, rdData[31:0]}, 64'hA5);

    applyStimulus(1'b1, 5'd6, 32'h00000066, 1'b1, 5'd6, 1'b0);
    tick();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0);
    setRead(5'd0, 5'd6);
    checkOutput("rsv_wins_pend6", {62'd0, rdPend}, 64'd2);
    checkOutput("rsv_wr_data6", {32'd0, rdData[63:32]}, 64'h66);

    for (int i = 1; i < 32; i++) begin
      applyStimulus(1'b1, 5'(i), 32'(i), 1'b0, 5'd0, 1'b0);
      tick();
    end
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 1'b0);
    tick();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0);
    setRead(5'd31, 5'd6);
    checkOutput("fill_31", {32'd0, rdData[31:0]}, 64'd31);
    checkOutput("fill_pend6", {62'd0, rdPend}, 64'd2);

    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1);
    tick();
    applyStimulus(1'b1, 5'd31, 32'h00000BAD, 1'b1, 5'd12, 1'b0);
    setRead(5'd9, 5'd10);
    busyCount  = 0;
    doneCount  = 0;
    busyAtDone = 0;
    for (int c = 0; c < 100; c++) begin
      #1;
      if (!clrBusy) break;
      busyCount++;
      if (clrDone) begin
        doneCount++;
        busyAtDone = busyCount;
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0);
      end
      if (busyCount == 10) begin
        checkOutput("mid_clr_walked9", {32'd0, rdData[31:0]}, 64'd0);
        checkOutput("mid_clr_unwalked10", {32'd0, rdData[63:32]}, 64'd10);
        checkOutput("mid_clr_no_byp", {32'd0, nbRdData[63:32]}, 64'd10);
      end
      tick();
    end
    checkOutput("clr_busy_cycles", 64'(busyCount), 64'd32);
    checkOutput("clr_done_pulses", 64'(doneCount), 64'd1);
    checkOutput("clr_done_last", 64'(busyAtDone), 64'd32);

    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0);
    orData = '0;
    orPend = 1'b0;
    for (int i = 1; i < 32; i++) begin
      setRead(5'(i), 5'(i));
      orData = orData | rdData[31:0] | rdData[63:32];
      orPend = orPend | rdPend[0] | rdPend[1];
    end
    checkOutput("post_clr_data_or", {32'd0, orData}, 64'd0);
    checkOutput("post_clr_pend_or", {63'd0, orPend}, 64'd0);
    setRead(5'd31, 5'd12);
    checkOutput("post_clr_wr_ignored", {32'd0, rdData[31:0]}, 64'd0);
    checkOutput("post_clr_rsv_ignored", {62'd0, rdPend}, 64'd0);

    applyStimulus(1'b1, 5'd20, 32'h00000020, 1'b1, 5'd25, 1'b0);
    tick();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1);
    tick();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0);
    repeat (9) tick();
    setRead(5'd20, 5'd25);
    checkOutput("pre_rst_busy", {63'd0, clrBusy}, 64'd1);
    checkOutput("pre_rst_e20", {32'd0, rdData[31:0]}, 64'h20);
    resetN = 1'b0;
    #1;
    checkOutput("mid_rst_busy", {63'd0, clrBusy}, 64'd0);
    checkOutput("mid_rst_done", {63'd0, clrDone}, 64'd0);
    checkOutput("mid_rst_e20", {32'd0, rdData[31:0]}, 64'd0);
    checkOutput("mid_rst_pend25", {62'd0, rdPend}, 64'd0);
    tick();
    resetN = 1'b1;
    tick();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1);
    tick();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0);
    checkOutput("reclr_busy", {63'd0, clrBusy}, 64'd1);
    sawDone = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (clrDone) begin
        sawDone = 1'b1;
        break;
      end
      tick();
    end
    checkOutput("reclr_done_seen", {63'd0, sawDone}, 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-read-port register file with a pending-write scoreboard and a sequenced bulk clear. It supersedes the fixed 32x32, two-read-port register file in the processor datapath. It adds these features:
- configurable width, depth and read-port count;
- write-to-read bypass;
- per-entry pending bits for hazard detection;
- a software-triggered clear that walks the array one entry per cycle.

All state is updated on the rising edge of `clk`.

## Interface
Parameters:
- DATA_W, 32, data width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
- NRD, 2, number of read ports (1..4)
- BYPASS, 1, 1 = same-cycle write data is forwarded to matching reads

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- rd_addr  in  NRD*ADDR_W  read addresses, port k at bits [k*ADDR_W +: ADDR_W]
- rd_data  out  NRD*DATA_W  read data, combinational
- rd_pend  out  NRD  pending bit of each read address, combinational
- wr_en  in  1  write strobe
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- rsv_en  in  1  mark entry `rsv_addr` as pending
- rsv_addr  in  ADDR_W  entry to reserve
- clr_req  in  1  request a bulk clear; single-cycle pulse
- clr_busy  out  1  high while a clear is in progress
- clr_done  out  1  one-cycle pulse when a clear completes

## Operation
Entry 0:
- Reads as 0 at all times.
- Writes and reserves to entry 0 are discarded.
- The pending bit of entry 0 is never set.

Read path:
- `rd_data[k] = 0` if `rd_addr[k]==0`.
- Otherwise, if BYPASS and `wr_en` is high, `wr_addr==rd_addr[k]` and the FSM is IDLE, `rd_data[k]` is `wr_data`.
- Otherwise `rd_data[k]` is the array entry.
- `rd_pend[k]` is the stored pending bit of the read address. It is not bypassed.

Write:
- When `wr_en` is high and the FSM is IDLE, the entry is updated on the rising edge and its pending bit is cleared.
- `wr_en` is ignored while `clr_busy` is high.

Reserve:
- When `rsv_en` is high and the FSM is IDLE, the pending bit of `rsv_addr` is set.
- If `rsv_en` and `wr_en` target the same address in the same cycle, reserve wins and the pending bit ends at 1. The data is still written.

Clear FSM states:
- IDLE: `clr_req` moves the FSM to CLEAR with the counter at 1.
- CLEAR: each cycle zeroes entry[counter] and pend[counter], then increments the counter. After entry DEPTH-1 is zeroed, the FSM moves to DONE.
- DONE: `clr_done`=1 for one cycle, then the FSM returns to IDLE.

Other clear rules:
- `clr_req` is ignored outside IDLE.
- `rsv_en` is ignored outside IDLE.

Reset (`reset_n` low, at any time including mid-clear):
- All entries and pending bits are set to 0.
- The FSM goes to IDLE and the counter to 0.
- `clr_busy`=0 and `clr_done`=0.

## Timing
- Read latency: 0 cycles (combinational from address).
- A written value is visible in the array the cycle after the write. With BYPASS it is also visible in the same cycle.
- A clear takes DEPTH-1 cycles in CLEAR plus 1 cycle in DONE.
- `clr_busy` rises the cycle after `clr_req` and stays high through DONE.
- `clr_done` is asserted in the last busy cycle.
- An entry already zeroed by the walk reads 0 while the clear is in progress. Entries not yet reached keep their old value.
- Counter arithmetic is ADDR_W bits. The counter stops at DEPTH-1 and does not wrap into entry 0.

## Structure
- Shared package `regfile_pkg` holds:
  - clear-FSM state enum {IDLE, CLEAR, DONE};
  - defaults for DATA_W, ADDR_W and NRD.
- The array, pending bits, bypass mux and a generate loop over NRD read ports live in the top module.
- Sub-module `regfile_clr_fsm` owns the state register and the counter. It outputs `clr_busy`, `clr_done`, clear-entry strobe and clear-entry address.

## Test plan
- Reset then read: `reset_n` low→high, then read addresses 0, 3 and 31 → `rd_data`=0, `rd_pend`=0 on every port.
- Write then read: write 0xDEADBEEF to entry 8. Next cycle port0=8, port1=0 → port0 reads 0xDEADBEEF, port1 reads 0.
- Bypass: write 0x12345678 to entry 4 while port1=4 in the same cycle → `rd_data[1]`=0x12345678. With BYPASS=0 the old value is read.
- Scoreboard: reserve entry 5, then read port0=5 → `rd_pend[0]`=1. Write 0xA5 to entry 5 → pend cleared next cycle. Reserve and write entry 6 in the same cycle → pend(6)=1, data=written value.
- Clear: fill entries 1..31 with index values, then pulse `clr_req`:
  - `clr_busy` is high for 32 cycles;
  - `clr_done` pulses once;
  - all reads then return 0;
  - `wr_en` during the clear has no effect.
- Reset mid-clear: assert `reset_n` low on cycle 10 of a clear → busy=0 immediately, all entries 0, and a new `clr_req` is accepted after release.
